iface_pipe_nested: RTL and testbench

// - Multi-channel valid/ready register pipeline built from nested interfaces.
// - Channel interface if_pipe_ch encloses nested interface if_pipe_stg; each stage register lives in an always_ff inside it.
// - CHANNELS independent lanes, each DEPTH stages deep. Output is read hierarchically from the last stage instance.
// - Successor to the single-register nested-interface block: adds width/depth/channel params, handshake, flush and occupancy.
//

---
 rtl/iface_pipe_nested.sv | 140 ++++++++++++++
 tb/tb_iface_pipe_nested.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iface_pipe_nested.sv
// Multi-lane valid/ready register pipeline built from nested interfaces (lane -> stage).
// Optional per-lane stall counter enabled by defining IFACE_PIPE_STALL_CNT_EN.

interface if_pipe_stg #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    input logic flush
);
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic             nxt_rdy;
    logic             adv;
    logic             v_nxt;
    logic             v;
    logic [WIDTH-1:0] d;

    assign adv   = !v || nxt_rdy;
    assign v_nxt = (rst || flush) ? 1'b0 : (adv ? src_v : v);

    // Bubbles and flushes leave the data register untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            v <= v_nxt;
            if (!flush && adv && src_v)
                d <= src_d;
        end
    end
endinterface

interface if_pipe_ch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int LVL_W = 2
) (
    input logic clk,
    input logic rst,
    input logic flush
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] lvl_nxt;
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v_nxt;

    if_pipe_stg #(.WIDTH(WIDTH)) u_stg [DEPTH] (.clk(clk), .rst(rst), .flush(flush));

    assign rdy[DEPTH] = out_ready;
    assign in_ready   = rdy[0];

    // Ready ripples back combinationally so any bubble is collapsed in one cycle
    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        assign u_stg[k].nxt_rdy = rdy[k+1];
        assign rdy[k]           = u_stg[k].adv;
        assign v_nxt[k]         = u_stg[k].v_nxt;
        if (k == 0) begin : g_head
            assign u_stg[k].src_v = in_valid;
            assign u_stg[k].src_d = in_data;
        end else begin : g_body
            assign u_stg[k].src_v = u_stg[k-1].v;
            assign u_stg[k].src_d = u_stg[k-1].d;
        end
    end

    assign out_valid = u_stg[DEPTH-1].v;
    assign out_data  = u_stg[DEPTH-1].d;

    always_comb begin
        lvl_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            lvl_nxt = lvl_nxt + LVL_W'(v_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) level <= '0;
        else     level <= lvl_nxt;
    end
endinterface

module iface_pipe_nested #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 3,
    parameter int CHANNELS = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic [CHANNELS-1:0]       i_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    output logic [CHANNELS-1:0]       o_ready,
    output logic [CHANNELS-1:0]       o_valid,
    output logic [CHANNELS*WIDTH-1:0] o_data,
    input  logic [CHANNELS-1:0]       i_ready,
    output logic [CHANNELS*$clog2(DEPTH+1)-1:0] o_level,
    output logic [CHANNELS*16-1:0]    o_stall_cnt
);
    localparam int LVL_W = $clog2(DEPTH+1);

    if_pipe_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_ch [CHANNELS] (
        .clk(i_clk), .rst(i_rst), .flush(i_flush)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign u_ch[c].in_valid             = i_valid[c];
        assign u_ch[c].in_data              = i_data[c*WIDTH +: WIDTH];
        assign u_ch[c].out_ready            = i_ready[c];
        assign o_ready[c]                   = u_ch[c].in_ready;
        assign o_valid[c]                   = u_ch[c].out_valid;
        assign o_data[c*WIDTH +: WIDTH]     = u_ch[c].out_data;
        assign o_level[c*LVL_W +: LVL_W]    = u_ch[c].level;
    end

`ifdef IFACE_PIPE_STALL_CNT_EN
    logic [CHANNELS-1:0][15:0] stall_cnt_q;

    // Saturating: a stuck lane pins at 16'hFFFF instead of wrapping to look idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                if (o_valid[c] && !i_ready[c] && stall_cnt_q[c] != 16'hFFFF)
                    stall_cnt_q[c] <= stall_cnt_q[c] + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_iface_pipe_nested.sv
// Directed bench for iface_pipe_nested with a beat-queue reference model checked every cycle.
module tb_iface_pipe_nested;
    localparam int W = 8, D = 3, CH = 2, LW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush;
    logic [CH-1:0]    iv, ir, ordy, ov;
    logic [CH*W-1:0]  id, od;
    logic [CH*LW-1:0] lvl;
    logic [CH*16-1:0] sc;

    iface_pipe_nested #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_valid(iv), .i_data(id), .o_ready(ordy),
        .o_valid(ov), .o_data(od), .i_ready(ir),
        .o_level(lvl), .o_stall_cnt(sc)
    );

    int checks = 0, errors = 0;
    bit mchk = 1'b0, seen55 = 1'b0;

    // Model: per lane, an ordered list of beats (oldest first) with their stage position
    int         mpos [CH][D];
    logic [7:0] mdat [CH][D];
    int         mn   [CH];
    int         mcnt [CH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            bit rdy, take, ovl;
            int lim;
            if (rst) begin
                mn[c] = 0; mcnt[c] = 0;
            end else begin
                rdy  = (mn[c] < D) || ir[c];
                take = iv[c] && rdy;
                ovl  = (mn[c] > 0) && (mpos[c][0] == D-1);
                if (ovl && !ir[c] && mcnt[c] < 65535) mcnt[c]++;
                if (flush) begin
                    mn[c] = 0;
                end else begin
                    if (ovl && ir[c]) begin
                        for (int i = 0; i < D-1; i++) begin
                            mpos[c][i] = mpos[c][i+1];
                            mdat[c][i] = mdat[c][i+1];
                        end
                        mn[c]--;
                    end
                    // each beat moves up one stage if the slot ahead is free after its elder moved
                    for (int i = 0; i < mn[c]; i++) begin
                        lim = (i == 0) ? D-1 : mpos[c][i-1] - 1;
                        if (mpos[c][i] < lim) mpos[c][i]++;
                    end
                    if (take) begin
                        mpos[c][mn[c]] = 0;
                        mdat[c][mn[c]] = id[c*W +: W];
                        mn[c]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ov[0] && od[7:0] == 8'h55) seen55 = 1'b1;
            if (mchk) begin
                for (int c = 0; c < CH; c++) begin
                    bit   e_ov;
                    logic [15:0] e_sc;
                    e_ov = (mn[c] > 0) && (mpos[c][0] == D-1);
`ifdef IFACE_PIPE_STALL_CNT_EN
                    e_sc = 16'(mcnt[c]);
`else
                    e_sc = 16'h0;
`endif
                    chk($sformatf("m_valid%0d", c), 32'(ov[c]), 32'(e_ov));
                    chk($sformatf("m_ready%0d", c), 32'(ordy[c]), 32'((mn[c] < D) || ir[c]));
                    chk($sformatf("m_level%0d", c), 32'(lvl[c*LW +: LW]), 32'(mn[c]));
                    chk($sformatf("m_stall%0d", c), 32'(sc[c*16 +: 16]), 32'(e_sc));
                    if (e_ov) chk($sformatf("m_data%0d", c), 32'(od[c*W +: W]), 32'(mdat[c][0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; iv = 2'b11; ir = 2'b11; id = 16'h3C5A;
        for (int i = 0; i < CH; i++) begin mn[i] = 0; mcnt[i] = 0; end
        tick(); tick();
        chk("rst_valid", 32'(ov), 32'h0);
        chk("rst_level", 32'(lvl), 32'h0);
        chk("rst_ready", 32'(ordy), 32'h3);
        chk("rst_stall", 32'(sc), 32'h0);
        chk("rst_data",  32'(od), 32'h0);
        rst = 1'b0; iv = 2'b00; mchk = 1'b1;

        // lane0 streaming 01..0A
        for (int i = 1; i <= 10; i++) begin
            iv[0] = 1'b1; id[7:0] = 8'(i);
            tick();
            if (i == 3) begin
                chk("lat_valid", 32'(ov[0]), 32'h1);
                chk("lat_data",  32'(od[7:0]), 32'h01);
            end
        end
        iv[0] = 1'b0;
        repeat (4) tick();

        // lane1 backpressure while lane0 streams
        ir = 2'b01;
        for (int j = 0; j < 4; j++) begin
            iv = 2'b11; id[7:0] = 8'(8'h10 + j); id[15:8] = 8'(8'hA0 + j);
            tick();
        end
        chk("bp_level",  32'(lvl[3:2]), 32'h3);
        chk("bp_ready",  32'(ordy[1]), 32'h0);
        chk("bp_hold",   32'(od[15:8]), 32'hA0);
        chk("bp_iso",    32'(ordy[0]), 32'h1);
        iv[0] = 1'b0; ir = 2'b11;
        tick();
        chk("rel_data",  32'(od[15:8]), 32'hA1);
        iv[1] = 1'b0;
        repeat (4) tick();

        // flush with lane0 holding two beats
        ir = 2'b10; iv = 2'b01; id[7:0] = 8'h20;
        tick();
        id[7:0] = 8'h21;
        tick();
        flush = 1'b1; id[7:0] = 8'h55;
        chk("fl_ready", 32'(ordy[0]), 32'h1);
        tick();
        flush = 1'b0; iv = 2'b00;
        chk("fl_valid", 32'(ov[0]), 32'h0);
        chk("fl_level", 32'(lvl[1:0]), 32'h0);
        ir = 2'b11;
        repeat (4) tick();

        // reset beats flush and fill
        ir = 2'b10; iv = 2'b01;
        for (int i = 0; i < 3; i++) begin id[7:0] = 8'(8'h30 + i); tick(); end
        iv = 2'b00;
        chk("rp_full", 32'(lvl[1:0]), 32'h3);
        rst = 1'b1; flush = 1'b1; iv = 2'b11;
        tick();
        chk("rp_valid", 32'(ov), 32'h0);
        chk("rp_level", 32'(lvl), 32'h0);
        chk("rp_ready", 32'(ordy), 32'h3);
        chk("rp_stall", 32'(sc), 32'h0);
        rst = 1'b0; flush = 1'b0; iv = 2'b00; ir = 2'b11;
        tick();

`ifdef IFACE_PIPE_STALL_CNT_EN
        ir = 2'b10; iv = 2'b01; id[7:0] = 8'h40;
        tick();
        iv = 2'b00;
        repeat (2) tick();
        repeat (5) tick();
        chk("sc_five",  32'(sc[15:0]), 32'h5);
        chk("sc_other", 32'(sc[31:16]), 32'h0);
        force dut.stall_cnt_q = 32'h0000_FFFE;
        #1;
        release dut.stall_cnt_q;
        mcnt[0] = 32'hFFFE; mcnt[1] = 0;
        repeat (3) tick();
        chk("sc_sat", 32'(sc[15:0]), 32'hFFFF);
        ir = 2'b11;
        repeat (2) tick();
`else
        ir = 2'b10; iv = 2'b01; id[7:0] = 8'h40;
        tick();
        iv = 2'b00;
        repeat (7) tick();
        chk("sc_off", 32'(sc), 32'h0);
        ir = 2'b11;
        repeat (2) tick();
`endif
        chk("no_55", 32'(seen55), 32'h0);
        mchk = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
